// File: rtl/pad_input_conditioner.sv
// Per-channel pad input conditioner: two-flop synchronizer, optional debounce, edge pulses and sticky interrupt pending bits.
// Optional feature macro: PAD_INPUT_DEBOUNCE_EN builds the per-channel debounce counters (default build passes raw straight to level).
module pad_input_conditioner #(
   parameter int NCH   = 8,
   parameter int DEB_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NCH-1:0]     pad_i,
   input  logic [NCH-1:0]     en_i,
   input  logic [NCH-1:0]     invert_i,
   input  logic [DEB_W-1:0]   deb_thresh_i,
   input  logic [2*NCH-1:0]   irq_mode_i,
   input  logic [NCH-1:0]     irq_clr_i,
   output logic [NCH-1:0]     level_o,
   output logic [NCH-1:0]     rise_o,
   output logic [NCH-1:0]     fall_o,
   output logic [NCH-1:0]     pending_o,
   output logic               irq_o
);

   logic [NCH-1:0] sync1;
   logic [NCH-1:0] sync2;
   logic [NCH-1:0] raw;
   logic [NCH-1:0] level;
   logic [NCH-1:0] level_nxt;
   logic [NCH-1:0] rise;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] pending;
   logic [NCH-1:0] set_pend;

   assign raw = sync2 ^ invert_i;

`ifdef PAD_INPUT_DEBOUNCE_EN
   logic [DEB_W-1:0] cnt [NCH];

   always_comb begin
      // NOTE: default assignment first so every path drives level_nxt and no latch is inferred.
      level_nxt = level;
      for (int i = 0; i < NCH; i++) begin
         if (raw[i] != level[i] && cnt[i] >= deb_thresh_i) level_nxt[i] = raw[i];
      end
   end

   // >= rather than == so a threshold lowered mid-count takes effect on the very next edge.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NCH; i++) begin
         // NOTE: the counter array is reset explicitly; a partial count must never survive reset.
         if (rst_i || !en_i[i] || raw[i] == level[i] || level_nxt[i] != level[i]) begin
            cnt[i] <= '0;
         end else if (cnt[i] != {DEB_W{1'b1}}) begin
            cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end
`else
   logic unused_deb_thresh;
   assign unused_deb_thresh = ^deb_thresh_i;
   assign level_nxt         = raw;
`endif

   always_comb begin
      set_pend = '0;
      for (int i = 0; i < NCH; i++) begin
         set_pend[i] = (rise[i] & irq_mode_i[2*i]) | (fall[i] & irq_mode_i[2*i+1]);
      end
   end

   // A disabled channel is held at zero without producing edge pulses; its pending bit is kept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         rise    <= '0;
         fall    <= '0;
         pending <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
         sync1   <= pad_i & en_i;
         sync2   <= sync1 & en_i;
         level   <= level_nxt & en_i;
         rise    <= level_nxt & ~level & en_i;
         fall    <= ~level_nxt & level & en_i;
         pending <= (pending & ~irq_clr_i) | set_pend;
      end
   end

   assign level_o   = level;
   assign rise_o    = rise;
   assign fall_o    = fall;
   assign pending_o = pending;
   assign irq_o     = |pending;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Self-checking bench for pad_input_conditioner: table of per-channel pulse scenarios plus directed corner sequences.
// Expected latencies depend on whether PAD_INPUT_DEBOUNCE_EN is defined for the build.
module tb_pad_input_conditioner;

   localparam int NCH   = 8;
   localparam int DEB_W = 8;
`ifdef PAD_INPUT_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [NCH-1:0]     pad;
   logic [NCH-1:0]     en;
   logic [NCH-1:0]     inv;
   logic [DEB_W-1:0]   thresh;
   logic [2*NCH-1:0]   mode;
   logic [NCH-1:0]     clr;
   logic [NCH-1:0]     level;
   logic [NCH-1:0]     rise;
   logic [NCH-1:0]     fall;
   logic [NCH-1:0]     pending;
   logic               irq;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pad_input_conditioner #(.NCH(NCH), .DEB_W(DEB_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .pad_i        (pad),
      .en_i         (en),
      .invert_i     (inv),
      .deb_thresh_i (thresh),
      .irq_mode_i   (mode),
      .irq_clr_i    (clr),
      .level_o      (level),
      .rise_o       (rise),
      .fall_o       (fall),
      .pending_o    (pending),
      .irq_o        (irq)
   );

   typedef struct {
      int       ch;
      int       thr;
      bit [1:0] md;
      int       hold;
      int       exp_lat;
      int       exp_rise;
      int       exp_fall;
      int       exp_pend;
      int       exp_pcyc;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_pulse(input int ch, input bit is_fall, input int budget, output bit found);
      found = 1'b0;
      for (int c = 0; c < budget && !found; c++) begin
         tick();
         if (is_fall ? fall[ch] : rise[ch]) found = 1'b1;
      end
   endtask

   initial begin
      bit found;
      int lat, rc, fc, pcyc, pulse_bad, others_bad, window;
      bit prev;

      rst = 1'b1; pad = '0; en = '1; inv = '0; thresh = '0; mode = '0; clr = '0;

      //              ch thr md     hold exp_lat        rise       fall       pend       pend cycle
      vecs[0] = '{0, 4,   2'b01, 30,  DEB ? 7 : 3,   1,         1,         1,         DEB ? 8 : 4};
      vecs[1] = '{1, 4,   2'b01, 3,   DEB ? 0 : 3,   DEB ? 0:1, DEB ? 0:1, DEB ? 0:1, DEB ? 0 : 4};
      vecs[2] = '{7, 2,   2'b10, 3,   DEB ? 5 : 3,   1,         1,         1,         DEB ? 9 : 7};
      vecs[3] = '{6, 0,   2'b11, 10,  3,             1,         1,         1,         4};
      vecs[4] = '{5, 200, 2'b00, 260, DEB ? 203 : 3, 1,         1,         0,         0};

      do_reset();
      check("reset_level",   {24'd0, level},   0);
      check("reset_rise",    {24'd0, rise},    0);
      check("reset_fall",    {24'd0, fall},    0);
      check("reset_pending", {24'd0, pending}, 0);
      check("reset_irq",     {31'd0, irq},     0);

      // Table-driven single-channel pulse scenarios
      for (int v = 0; v < 5; v++) begin
         do_reset();
         thresh = vecs[v].thr[DEB_W-1:0];
         mode   = '0;
         mode[2*vecs[v].ch +: 2] = vecs[v].md;
         pad    = '0;
         pad[vecs[v].ch] = 1'b1;
         lat = 0; rc = 0; fc = 0; pcyc = 0; pulse_bad = 0; others_bad = 0;
         prev   = 1'b0;
         window = vecs[v].hold + vecs[v].thr + 10;
         for (int c = 1; c <= window; c++) begin
            if (c == vecs[v].hold + 1) pad[vecs[v].ch] = 1'b0;
            tick();
            if (level[vecs[v].ch] && !prev && lat == 0) lat = c;
            if (pending[vecs[v].ch] && pcyc == 0) pcyc = c;
            rc += int'(rise[vecs[v].ch]);
            fc += int'(fall[vecs[v].ch]);
            if (rise[vecs[v].ch] !== (level[vecs[v].ch] & ~prev)) pulse_bad++;
            if (fall[vecs[v].ch] !== (~level[vecs[v].ch] & prev)) pulse_bad++;
            if (((level | rise | fall | pending) & ~(8'd1 << vecs[v].ch)) != '0) others_bad++;
            prev = level[vecs[v].ch];
         end
         check($sformatf("v%0d_latency", v),     lat, vecs[v].exp_lat);
         check($sformatf("v%0d_rise_count", v),  rc,  vecs[v].exp_rise);
         check($sformatf("v%0d_fall_count", v),  fc,  vecs[v].exp_fall);
         check($sformatf("v%0d_pending", v),     {31'd0, pending[vecs[v].ch]}, vecs[v].exp_pend);
         check($sformatf("v%0d_irq", v),         {31'd0, irq}, vecs[v].exp_pend);
         check($sformatf("v%0d_pend_cycle", v),  pcyc, vecs[v].exp_pcyc);
         check($sformatf("v%0d_pulse_align", v), pulse_bad, 0);
         check($sformatf("v%0d_other_ch", v),    others_bad, 0);
         check($sformatf("v%0d_final_level", v), {31'd0, level[vecs[v].ch]}, 0);
      end

      // ch2 mode both: clear alone empties pending, clear coinciding with a fall keeps it set
      do_reset();
      thresh = 8'd4; mode = '0; mode[5:4] = 2'b11; pad = '0;
      pad[2] = 1'b1;
      wait_pulse(2, 1'b0, 30, found);
      check("ch2_rise_seen", {31'd0, found}, 1);
      tick();
      check("ch2_pending_after_rise", {31'd0, pending[2]}, 1);
      check("ch2_irq_after_rise",     {31'd0, irq}, 1);
      clr[2] = 1'b1;
      tick();
      clr[2] = 1'b0;
      check("ch2_pending_cleared", {31'd0, pending[2]}, 0);
      check("ch2_irq_cleared",     {31'd0, irq}, 0);
      repeat (15) tick();
      pad[2] = 1'b0;
      wait_pulse(2, 1'b1, 30, found);
      check("ch2_fall_seen", {31'd0, found}, 1);
      clr[2] = 1'b1;
      tick();
      clr[2] = 1'b0;
      check("ch2_set_beats_clear", {31'd0, pending[2]}, 1);
      clr[2] = 1'b1;
      tick();
      clr[2] = 1'b0;
      check("ch2_final_clear", {31'd0, pending[2]}, 0);

      // ch3 inverted, pad low from reset, T=0
      inv = '0; inv[3] = 1'b1; pad = '0; thresh = '0; mode = '0; mode[7:6] = 2'b01;
      do_reset();
      rc = 0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         rc += int'(rise[3]);
         if (c == 3) check("ch3_level_at_3", {31'd0, level[3]}, 1);
      end
      check("ch3_rise_once", rc, 1);
      inv = '0;

      // ch4 enable drop and re-enable
      do_reset();
      thresh = 8'd4; mode = '0; mode[9:8] = 2'b01; pad = '0;
      pad[4] = 1'b1;
      wait_pulse(4, 1'b0, 30, found);
      check("ch4_rise_seen", {31'd0, found}, 1);
      tick();
      tick();
      en[4] = 1'b0;
      tick();
      check("ch4_level_disabled", {31'd0, level[4]}, 0);
      fc = int'(fall[4]);
      repeat (10) begin
         tick();
         fc += int'(fall[4]);
      end
      check("ch4_no_fall", fc, 0);
      check("ch4_pending_kept", {31'd0, pending[4]}, 1);
      en[4] = 1'b1;
      lat = 0; rc = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (level[4] && lat == 0) lat = c;
         rc += int'(rise[4]);
      end
      check("ch4_reenable_latency", lat, DEB ? 7 : 3);
      check("ch4_reenable_rise",    rc, 1);

      // ch5 reset mid-count
      do_reset();
      thresh = 8'd4; mode = '1; pad = '0;
      pad[5] = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      pad[5] = 1'b0;
      tick();
      check("rst_mid_outputs", {24'd0, level | rise | fall | pending}, 0);
      check("rst_mid_irq",     {31'd0, irq}, 0);
      rst = 1'b0;
      pulse_bad = 0;
      repeat (15) begin
         tick();
         if ((rise | fall | pending) != '0) pulse_bad++;
      end
      check("rst_release_quiet", pulse_bad, 0);

      // ch6 threshold lowered mid-count
      do_reset();
      thresh = 8'd20; mode = '0; pad = '0;
      pad[6] = 1'b1;
      lat = 0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 11) thresh = 8'd4;
         tick();
         if (level[6] && lat == 0) lat = c;
      end
      check("ch6_thresh_change_latency", lat, DEB ? 11 : 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
